// File: rtl/tdm_mux_scanner.sv
// tdm_mux_scanner: captures an 8-bit word and serializes it over an address/data link,
// one bit per DIV-cycle slot, for a downstream select/data demux.
module tdm_mux_scanner #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic [7:0] din,
  output logic [2:0] A,
  output logic       data,
  output logic       valid,
  output logic       sync,
  output logic       busy,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  state_t     state_q;
  logic [7:0] shadow_q, div_q;
  logic [2:0] a_q, a_d;
  logic       data_q, valid_q, sync_q, busy_q, done_q;
  logic       slot_end_d, frame_end_d;
  assign slot_end_d  = div_q == DIV_LAST;
  assign frame_end_d = slot_end_d && a_q == 3'd7;
  assign a_d         = a_q + 3'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      div_q    <= '0;
      a_q      <= '0;
      data_q   <= 1'b0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q  <= SHIFT;
            shadow_q <= din;
            div_q    <= '0;
            a_q      <= '0;
            data_q   <= din[0];
            valid_q  <= 1'b1;
            sync_q   <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          if (!slot_end_d) begin
            div_q  <= div_q + 8'd1;
            sync_q <= 1'b0;
          end else if (!frame_end_d) begin
            div_q  <= '0;
            a_q    <= a_d;
            data_q <= shadow_q[a_d];
            sync_q <= 1'b0;
          end else if (cont) begin
            // Continuous mode rolls straight into the next frame with a fresh capture
            div_q    <= '0;
            a_q      <= '0;
            shadow_q <= din;
            data_q   <= din[0];
            sync_q   <= 1'b1;
          end else begin
            state_q <= DONE;
            div_q   <= '0;
            a_q     <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign A     = a_q;
  assign data  = data_q;
  assign valid = valid_q;
  assign sync  = sync_q;
  assign busy  = busy_q;
  assign done  = done_q;
endmodule

// File: tb/tb_tdm_mux_scanner.sv
// tb_tdm_mux_scanner: runs DIV=4 and DIV=1 instances side by side against a frame-position
// reference model, plus directed latency, continuous-mode, reset and loopback checks.
module tb_tdm_mux_scanner;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cont = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] a4, a1;
  logic d4, v4, s4, b4, dn4, d1, v1, s1, b1, dn1;
  int errs = 0, checks = 0;
  int dv [2] = '{4, 1};
  bit m_in [2];
  bit m_done [2];
  int m_n [2];
  logic [7:0] m_sh [2];
  logic [7:0] acc [2];
  int lat4, lat1, cnt;
  logic [7:0] words [3] = '{8'h00, 8'h5A, 8'hC3};

  always #5 clk = ~clk;

  tdm_mux_scanner #(.DIV(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .din(din),
    .A(a4), .data(d4), .valid(v4), .sync(s4), .busy(b4), .done(dn4));
  tdm_mux_scanner #(.DIV(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .din(din),
    .A(a1), .data(d1), .valid(v1), .sync(s1), .busy(b1), .done(dn1));

  function automatic logic [7:0] obs(int i);
    return i == 0 ? {a4, d4, v4, s4, b4, dn4} : {a1, d1, v1, s1, b1, dn1};
  endfunction

  // Position n (1..8*DIV) within the frame fixes slot k = (n-1)/DIV and everything else
  function automatic logic [7:0] expv(int i);
    int k;
    if (!m_in[i]) return {7'd0, m_done[i]};
    k = (m_n[i] - 1) / dv[i];
    return {3'(k), m_sh[i][k], 1'b1, m_n[i] == 1, 1'b1, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_in[i] = 0; m_done[i] = 0; m_n[i] = 0; m_sh[i] = 8'h00;
    end
  endtask

  task automatic model_step(input int i);
    if (m_in[i]) begin
      if (m_n[i] == 8 * dv[i]) begin
        if (cont) begin m_sh[i] = din; m_n[i] = 1; end
        else begin m_in[i] = 0; m_done[i] = 1; end
      end else m_n[i]++;
    end else begin
      m_done[i] = 0;
      if (start) begin m_in[i] = 1; m_n[i] = 1; m_sh[i] = din; end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    chk("div4", obs(0), expv(0));
    chk("div1", obs(1), expv(1));
    if (v4 && d4) acc[0][a4] = 1'b1;
    if (v1 && d1) acc[1][a1] = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 chk("rst_async4", obs(0), 8'h00);
    chk("rst_async1", obs(1), 8'h00);
    model_reset();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    run(2);
    rst_n = 1'b1;
    run(2);
    // single frame DIV=4 with A6; DIV=1 instance finishes at T+9
    din = 8'b1010_0110; start = 1'b1; lat4 = 0; lat1 = 0;
    for (int c = 1; c <= 40; c++) begin
      cyc();
      start = 1'b0;
      if (dn4 && lat4 == 0) lat4 = c;
      if (dn1 && lat1 == 0) lat1 = c;
    end
    chk("done_lat4", 8'(lat4), 8'd33);
    chk("done_lat1", 8'(lat1), 8'd9);
    // DIV=1 all-ones: exactly 8 data-high cycles
    din = 8'hFF; start = 1'b1; cnt = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      start = 1'b0;
      if (d1) cnt++;
    end
    chk("div1_ones", 8'(cnt), 8'd8);
    run(30);
    // continuous mode: 01 then 80, no gap between frames
    din = 8'h01; cont = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    run(9);
    din = 8'h80;
    run(23);
    chk("cont_sync", {6'd0, s4, b4}, 8'h03);
    run(10);
    cont = 1'b0;
    run(40);
    // start held high across frames
    din = 8'(($urandom)); start = 1'b1;
    run(80);
    start = 1'b0;
    run(40);
    // mid-frame abort, then stays idle
    din = 8'h3C; start = 1'b1;
    cyc();
    start = 1'b0;
    run(10);
    async_reset();
    run(5);
    chk("abort_idle", {6'd0, b4, dn4}, 8'h00);
    // loopback through an OR-accumulating demux
    for (int w = 0; w < 3; w++) begin
      run(3);
      acc[0] = 8'h00; acc[1] = 8'h00;
      din = words[w]; start = 1'b1;
      cyc();
      start = 1'b0;
      run(34);
      chk("loop4", acc[0], words[w]);
      chk("loop1", acc[1], words[w]);
    end
    // random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      start = $urandom_range(0, 3) == 0;
      cont = $urandom_range(0, 3) == 0;
      din = 8'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset();
      else cyc();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/tdm_mux_scanner.md
Name: tdm_mux_scanner

Overview:
Time-division 8-to-1 multiplexer/serializer: the transmit-side counterpart of the team's 3-bit-select 1-to-8 LED demux. It captures an 8-bit parallel word, then walks a 3-bit address 0..7. For each address it presents the matching bit on a single data line, so a downstream select/data demux can reconstruct the word. It sits between the board switches and the demux/LED path, or any select+data link.

Parameters:
DIV, 4, clock cycles per address slot; legal range 1..255.

Ports:
clk    input   1  system clock, rising edge
rst_n  input   1  asynchronous active-low reset
start  input   1  request one frame; sampled in IDLE and DONE only
cont   input   1  continuous mode; sampled on the last cycle of each frame
din    input   8  parallel word; captured into shadow register at frame start
A      output  3  current slot address (select to demux)
data   output  1  shadow[A] during a valid slot, else 0
valid  output  1  high for every cycle of every slot
sync   output  1  high only on the first cycle of slot 0
busy   output  1  high while a frame is in progress
done   output  1  one-cycle pulse after a non-continuous frame ends

Behaviour:
- One clock domain. All outputs registered.
- Reset: asynchronous on rst_n low; released synchronously to clk.
- Reset values: A=0, data=0, valid=0, sync=0, busy=0, done=0, shadow=0, state=IDLE, slot counter=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Outputs at reset values.
  - start=1 in cycle T: capture din into shadow, go to SHIFT.
  - Cycle T+1: busy=1, valid=1, A=0, sync=1, data=din_captured[0].
- SHIFT:
  - Slot k (k=0..7) occupies cycles T+1+k*DIV through T+(k+1)*DIV.
  - A=k and data=shadow[k] are held constant for the whole slot.
  - The divider counts 0..DIV-1. At DIV-1 it wraps to 0 and A increments.
  - DIV=1: A changes every cycle.
- Frame end (last cycle of slot 7, cycle T+8*DIV):
  - cont=1: recapture din into shadow; next cycle starts slot 0 with sync=1 and no idle gap; busy stays 1.
  - cont=0: go to DONE.
- DONE (cycle T+1+8*DIV):
  - done=1, busy=0, valid=0, data=0, sync=0, A=0.
  - start=1 in this cycle behaves exactly as start in IDLE (back-to-back frames with a one-cycle gap).
  - Otherwise go to IDLE next cycle.
- start while busy: ignored; no restart, no queuing.
- din changes mid-frame: no effect on the current frame; only the shadow register drives data.
- cont: sampled only at frame end; toggling it mid-frame has no effect until then.
- rst_n asserted mid-frame: immediate abort to reset values. No done pulse. After release the block waits for a new start.
- Latency: start to first valid bit is 1 cycle. Non-continuous frame length is 8*DIV cycles, plus 1 DONE cycle.

Test Plan:
- Reset: rst_n=0 mid-operation -> all outputs 0 asynchronously, before the next clk edge; after release, state is IDLE with busy=0.
- Single frame, DIV=4, din=8'b1010_0110, start pulse at T:
  - A steps 0..7, each held 4 cycles; data sequence 0,1,1,0,0,1,0,1; sync only at T+1.
  - done=1 at T+33; busy=0 from T+33.
- DIV=1, din=8'hFF, start: data=1 for exactly 8 consecutive cycles with A=0..7; done at T+9.
- Continuous mode, cont=1, din=8'h01 then changed to 8'h80 mid-frame 1:
  - Frame 1 serializes 01.
  - Frame 2 starts with no gap, sync=1 again, and serializes 80.
  - Dropping cont during frame 2 yields done after frame 2.
- start held high throughout a frame: no restart mid-frame; a second frame begins right after the DONE cycle.
- Loopback: feed A/data into the existing demux and OR-accumulate its 8 outputs over one frame -> reconstructed word equals din for 8'h00, 8'h5A, 8'hC3.
